// File: rtl/fifo_reader.sv
// fifo_reader
//   Drains the read side of a dual-clock FIFO into a ready/valid stream.
//   A 2-entry in-order skid buffer absorbs the one-cycle FIFO read latency,
//   so the stream can move one word per cycle while m_ready stays high.
//   Frames are FRAME_LEN words long, and m_last marks the final word of
//   each frame.
//
// Ports
//   rd_clk      in   single clock; all state updates on its rising edge
//   areset_n    in   synchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_q      in   FIFO read data, valid the cycle after fifo_read
//   fifo_read   out  FIFO read strobe (combinational)
//   m_data      out  stream data (buffer head)
//   m_valid     out  stream data valid
//   m_ready     in   downstream accepts data
//   m_last      out  last word of the current frame
//   word_cnt    out  total words transferred, modulo 2^16
module fifo_reader #(
  parameter int DWIDTH    = 16,
  parameter int FRAME_LEN = 32
) (
  input  logic              rd_clk,
  input  logic              areset_n,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              fifo_read,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       word_cnt
);

  localparam int             FW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0]  FIDX_MAX = FW'(FRAME_LEN - 1);

  logic [DWIDTH-1:0] slot0;   // buffer head
  logic [DWIDTH-1:0] slot1;   // buffer second entry
  logic [1:0]        occ;
  logic              infl;
  logic [FW-1:0]     fidx;
  logic [15:0]       cnt;

  logic              pop;
  logic [2:0]        load;

  always_comb begin
    m_valid   = areset_n & (occ != 2'd0);
    pop       = m_valid & m_ready;
    // Slots committed after this edge: buffered + in flight - leaving now.
    // pop implies occ >= 1, so this never underflows.
    load      = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    fifo_read = areset_n & ~fifo_empty & (load < 3'd2);
    m_last    = m_valid & (fidx == FIDX_MAX);
    m_data    = slot0;
    word_cnt  = areset_n ? cnt : '0;
  end

  always_ff @(posedge rd_clk) begin
    if (!areset_n) begin
      occ  <= '0;
      infl <= 1'b0;
      fidx <= '0;
      cnt  <= '0;
    end else begin
      infl <= fifo_read;

      if (pop) begin
        fidx <= (fidx == FIDX_MAX) ? '0 : fidx + 1'b1;
        cnt  <= cnt + 16'd1;
      end

      // Capture lands at the tail; a simultaneous pop shifts the head out
      // first, so the tail position depends on occupancy.
      case ({infl, pop})
        2'b11: begin
          if (occ == 2'd2) begin
            slot0 <= slot1;
            slot1 <= fifo_q;
          end else begin
            slot0 <= fifo_q;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) slot0 <= fifo_q;
          else             slot1 <= fifo_q;
          occ <= occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
//   Self-checking bench for fifo_reader (FRAME_LEN overridden to 4).
//   The FIFO is modelled as a queue; the expected stream is a queue of
//   words that have landed in the reader, checked every cycle.
module tb_fifo_reader;

  localparam int DW = 16;
  localparam int FL = 4;

  logic          rd_clk = 1'b0;
  logic          areset_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_read;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [15:0]   word_cnt;

  fifo_reader #(.DWIDTH(DW), .FRAME_LEN(FL)) dut (
    .rd_clk     (rd_clk),
    .areset_n   (areset_n),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_read  (fifo_read),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .word_cnt   (word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mq[$];      // FIFO contents
  logic [DW-1:0] landed[$];  // words visible to the stream, in order
  int            pend = 0;   // a read was issued last cycle
  logic [DW-1:0] pend_word = '0;
  int            xfers = 0;  // transfers since reset
  int            rd_cnt = 0; // reads issued since last cleared
  int            last_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    mq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, then advance the models.
  task automatic step();
    logic          rd, v, lst;
    logic [DW-1:0] d;
    logic [15:0]   wc;
    int            pop, exp_rd;
    @(negedge rd_clk);
    rd = fifo_read; v = m_valid; d = m_data; lst = m_last; wc = word_cnt;
    pop = 0;
    if (!areset_n) begin
      chk("rst_valid", {31'b0, v}, 0);
      chk("rst_last", {31'b0, lst}, 0);
      chk("rst_read", {31'b0, rd}, 0);
      chk("rst_cnt", {16'b0, wc}, 0);
    end else begin
      chk("m_valid", {31'b0, v}, (landed.size() != 0) ? 1 : 0);
      if (landed.size() != 0) chk("m_data", {16'b0, d}, {16'b0, landed[0]});
      chk("m_last", {31'b0, lst},
          ((landed.size() != 0) && (xfers % FL == FL - 1)) ? 1 : 0);
      chk("word_cnt", {16'b0, wc}, xfers & 32'hFFFF);
      pop = ((landed.size() != 0) && m_ready) ? 1 : 0;
      exp_rd = ((mq.size() != 0) && (landed.size() + pend - pop < 2)) ? 1 : 0;
      chk("fifo_read", {31'b0, rd}, exp_rd);
      if (v && m_ready && lst) last_cnt++;
    end
    @(posedge rd_clk);
    #1;
    if (!areset_n) begin
      landed.delete();
      mq.delete();
      pend = 0;
      xfers = 0;
      fifo_empty = 1'b1;
    end else begin
      if (pop != 0) begin
        void'(landed.pop_front());
        xfers++;
      end
      if (pend != 0) landed.push_back(pend_word);
      tests++;
      assert (landed.size() <= 2) else begin
        fails++;
        $error("FAIL overflow observed=%0d expected<=2", landed.size());
      end
      pend = rd ? 1 : 0;
      if (rd) begin
        rd_cnt++;
        pend_word = (mq.size() != 0) ? mq.pop_front() : 16'hBAD0;
        fifo_q = pend_word;
      end
      fifo_empty = (mq.size() == 0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int base;

  initial begin
    // Reset state
    areset_n = 1'b0;
    steps(3);
    areset_n = 1'b1;

    // Preloaded 1..5, sink always ready
    for (int i = 1; i <= 5; i++) push(16'(i));
    m_ready = 1'b1;
    rd_cnt = 0;
    steps(10);
    chk("burst_reads", rd_cnt, 5);
    chk("burst_cnt", {16'b0, word_cnt}, 5);

    // Backpressure: 4 words, sink stalled for 10 cycles
    for (int i = 0; i < 4; i++) push(16'($urandom));
    m_ready = 1'b0;
    rd_cnt = 0;
    base = xfers;
    steps(10);
    chk("stall_reads", rd_cnt, 2);
    m_ready = 1'b1;
    steps(8);
    chk("stall_xfers", xfers - base, 4);

    // Framing: 9 words from a fresh reset
    areset_n = 1'b0;
    steps(1);
    areset_n = 1'b1;
    for (int i = 0; i < 9; i++) push(16'($urandom));
    last_cnt = 0;
    steps(14);
    chk("frame_lasts", last_cnt, 2);
    chk("frame_xfers", xfers, 9);

    // Toggling ready, 20 random words
    base = xfers;
    for (int i = 0; i < 20; i++) push(16'($urandom));
    for (int i = 0; i < 50; i++) begin
      m_ready = i[0];
      step();
    end
    m_ready = 1'b1;
    steps(4);
    chk("toggle_xfers", xfers - base, 20);

    // Random ready with random arrivals
    base = xfers;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) push(16'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Reset while the buffer is loaded and a read is in flight
    areset_n = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(16'($urandom));
    steps(2);
    m_ready = 1'b1;
    step();
    areset_n = 1'b0;
    step();
    areset_n = 1'b1;
    m_ready = 1'b0;
    step();
    chk("post_rst_valid", {31'b0, m_valid}, 0);
    chk("post_rst_cnt", {16'b0, word_cnt}, 0);
    for (int i = 0; i < 3; i++) push(16'hA000 + 16'(i));
    m_ready = 1'b1;
    steps(8);
    chk("post_rst_xfers", xfers, 3);

    // Counter wrap: 65537 words
    areset_n = 1'b0;
    step();
    areset_n = 1'b1;
    for (int i = 0; i < 65537; i++) push(16'($urandom));
    m_ready = 1'b1;
    steps(65537 + 4);
    chk("wrap_cnt", {16'b0, word_cnt}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
